// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute/memory slice: data width and ALU operation encoding.
package ex_mem_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
  localparam logic [OP_W-1:0] ALU_SLL   = 5'd2;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'd3;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'd4;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL   = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRA   = 5'd7;
  localparam logic [OP_W-1:0] ALU_OR    = 5'd8;
  localparam logic [OP_W-1:0] ALU_AND   = 5'd9;
  localparam logic [OP_W-1:0] ALU_PASSB = 5'd10;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Pure combinational RV32 ALU: two operands and an op code in, one result out.
module ex_alu
  import ex_mem_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  always_comb begin
    // NOTE: default first so every path assigns o_result and no latch is inferred.
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute + memory slice: operand muxes, ALU, equality comparator and word-addressed data memory.
// Define EX_MEM_BRLT_EN to add the br_un input and br_lt less-than comparator output.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int VERIFY_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              alu_src1,
  input  logic              alu_src2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic              mem_we,
`ifdef EX_MEM_BRLT_EN
  input  logic              br_un,
  output logic              br_lt,
`endif
  output logic [OP_W-1:0]   alu_op_o,
  output logic [XLEN-1:0]   alu_out,
  output logic              br_eq,
  output logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   verify
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] VERIFY_IDX = VERIFY_ADDR[AW-1:0];

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] r_mem [DEPTH];

  assign w_a = alu_src1 ? pc  : rs1_data;
  assign w_b = alu_src2 ? imm : rs2_data;

  ex_alu u_alu (
    .i_op     (alu_op_i),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu)
  );

  // Byte address -> word index; the two low bits and anything above the array wrap away.
  assign w_idx = w_alu[AW+1:2];

  // NOTE: the data array is cleared by reset on purpose: software relies on zeroed memory,
  // so every word carries the async clear rather than being left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (mem_we) begin
      // NOTE: non-blocking so the asynchronous read below sees old data until after the edge.
      r_mem[w_idx] <= rs2_data;
    end
  end

  assign alu_op_o  = rst ? '0 : alu_op_i;
  assign alu_out   = rst ? '0 : w_alu;
  assign br_eq     = ~rst & (rs1_data == rs2_data);
  assign mem_rdata = rst ? '0 : r_mem[w_idx];
  assign verify    = rst ? '0 : r_mem[VERIFY_IDX];

`ifdef EX_MEM_BRLT_EN
  assign br_lt = ~rst & (br_un ? (rs1_data < rs2_data)
                               : ($signed(rs1_data) < $signed(rs2_data)));
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int VA    = 3;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_op_i;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        alu_src1, alu_src2, mem_we;
  logic [4:0]  alu_op_o;
  logic [31:0] alu_out, mem_rdata, verify;
  logic        br_eq;
`ifdef EX_MEM_BRLT_EN
  logic        br_un;
  logic        br_lt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [DEPTH];

  ex_mem_stage #(.DEPTH(DEPTH), .VERIFY_ADDR(VA)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_op_i  (alu_op_i),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .imm       (imm),
    .pc        (pc),
    .mem_we    (mem_we),
`ifdef EX_MEM_BRLT_EN
    .br_un     (br_un),
    .br_lt     (br_lt),
`endif
    .alu_op_o  (alu_op_o),
    .alu_out   (alu_out),
    .br_eq     (br_eq),
    .mem_rdata (mem_rdata),
    .verify    (verify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the instruction semantics, not the RTL structure.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    s = b % 32;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a + (~b + 32'd1);
      5'd2:  return a * (32'd1 << s);
      5'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a / (32'd1 << s);
      5'd7: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        return (a >> s) | fill;
      end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int unsigned word_of(input logic [31:0] byte_addr);
    return (byte_addr / 32'd4) % DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b, e_alu, e_rd, e_ver;
    logic [4:0]  e_op;
    logic        e_eq;
    a     = alu_src1 ? pc  : rs1_data;
    b     = alu_src2 ? imm : rs2_data;
    e_alu = ref_alu(alu_op_i, a, b);
    e_op  = alu_op_i;
    e_eq  = (rs1_data == rs2_data);
    e_rd  = mdl_mem[word_of(e_alu)];
    e_ver = mdl_mem[VA];
    if (rst) begin
      e_alu = '0; e_op = '0; e_eq = 1'b0; e_rd = '0; e_ver = '0;
    end
    check({tag, ".alu_out"},   alu_out,   e_alu);
    check({tag, ".alu_op_o"},  {27'd0, alu_op_o}, {27'd0, e_op});
    check({tag, ".br_eq"},     {31'd0, br_eq}, {31'd0, e_eq});
    check({tag, ".mem_rdata"}, mem_rdata, e_rd);
    check({tag, ".verify"},    verify,    e_ver);
`ifdef EX_MEM_BRLT_EN
    begin
      logic e_lt;
      e_lt = br_un ? (rs1_data < rs2_data)
                   : ((rs1_data ^ 32'h8000_0000) < (rs2_data ^ 32'h8000_0000));
      if (rst) e_lt = 1'b0;
      check({tag, ".br_lt"}, {31'd0, br_lt}, {31'd0, e_lt});
    end
`endif
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic s1, input logic s2, input logic [31:0] im,
                       input logic [31:0] p, input logic we);
    alu_op_i = op; rs1_data = r1; rs2_data = r2; alu_src1 = s1; alu_src2 = s2;
    imm = im; pc = p; mem_we = we;
    #1;
  endtask

  // Advance one rising edge, committing any write to the model, and return at the next falling edge.
  task automatic edge_step();
    logic        do_wr;
    int unsigned idx;
    logic [31:0] data;
    do_wr = mem_we && !rst;
    idx   = word_of(ref_alu(alu_op_i, alu_src1 ? pc : rs1_data, alu_src2 ? imm : rs2_data));
    data  = rs2_data;
    @(posedge clk);
    if (do_wr && !rst) mdl_mem[idx] = data;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endtask

  initial begin
    rst = 1'b0;
`ifdef EX_MEM_BRLT_EN
    br_un = 1'b0;
`endif
    drive(5'd0, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    check("reset.br_eq_zero", {31'd0, br_eq}, 32'd0);
    edge_step();
    rst = 1'b0;

    // ADD
    drive(ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("add.const", alu_out, 32'd12);
    check("add.br_eq", {31'd0, br_eq}, 32'd0);
    check_all("add");

    // SUB / SRA / SLT / SLTU with immediate operand
    drive(ALU_SUB, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
    check("sub.const", alu_out, 32'hFFFF_FFEC);
    check_all("sub");
    drive(ALU_SRA, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
    check("sra.const", alu_out, 32'hFFFF_FFFF);
    drive(ALU_SLT, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
    check("slt.const", alu_out, 32'd1);
    drive(ALU_SLTU, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
    check("sltu.const", alu_out, 32'd0);
    drive(5'd11, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
    check("op11.const", alu_out, 32'd0);
    drive(5'd31, 32'h1234_5678, 32'd9, 1'b0, 1'b0, 32'd4, 32'd0, 1'b0);
    check("op31.const", alu_out, 32'd0);

    // Branch target from pc + imm, equality on raw registers
    drive(ALU_ADD, 32'd9, 32'd9, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h40, 1'b0);
    check("br_target.const", alu_out, 32'h38);
    check("br_eq.const", {31'd0, br_eq}, 32'd1);
    check_all("branch");

    // Store then load; same-cycle read returns old data
    drive(ALU_ADD, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd8, 32'd0, 1'b1);
    check("store.before", mem_rdata, 32'd0);
    edge_step();
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd0, 1'b0);
    check("load.after", mem_rdata, 32'hDEAD_BEEF);
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'hA, 32'd0, 1'b0);
    check("load.lowbits", mem_rdata, 32'hDEAD_BEEF);
    check_all("load");
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8 + 32'(DEPTH * 4), 32'd0, 1'b0);
    check("load.wrap", mem_rdata, 32'hDEAD_BEEF);

    // verify port
    drive(ALU_ADD, 32'd0, 32'h1234, 1'b0, 1'b1, 32'(VA * 4), 32'd0, 1'b1);
    check("verify.before", verify, 32'd0);
    edge_step();
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("verify.after", verify, 32'h1234);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r1, r2;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom);
`ifdef EX_MEM_BRLT_EN
      br_un = 1'($urandom_range(0, 1));
`endif
      drive(5'($urandom_range(0, 13)), r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 1'($urandom_range(0, 1)));
      check_all("rand");
      edge_step();
    end

    // Reset mid-cycle after stores, with a write pending across the reset edge
    drive(ALU_ADD, 32'd0, 32'hCAFE_0001, 1'b0, 1'b1, 32'h100, 32'd0, 1'b1);
    edge_step();
    drive(ALU_ADD, 32'd0, 32'hCAFE_0002, 1'b0, 1'b1, 32'(VA * 4), 32'd0, 1'b1);
    edge_step();
    drive(ALU_ADD, 32'd7, 32'hCAFE_0003, 1'b0, 1'b1, 32'h104, 32'd0, 1'b1);
    check("prereset.verify", verify, 32'hCAFE_0002);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("midreset");
    check("midreset.alu_out", alu_out, 32'd0);
    check("midreset.verify", verify, 32'd0);
    edge_step();
    rst = 1'b0;
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'h100, 32'd0, 1'b0);
    check("postreset.word100", mem_rdata, 32'd0);
    check("postreset.verify", verify, 32'd0);
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'h104, 32'd0, 1'b0);
    check("postreset.word104", mem_rdata, 32'd0);
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd0, 1'b0);
    check("postreset.word8", mem_rdata, 32'd0);
    check_all("postreset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
